// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with 3-sample majority vote, framing/overrun detection and FWFT FIFO.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_param #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                          clk_rf,
   input  logic                          rst_n_rf,
   input  logic                          rx_in,
   input  logic                          rd_en,
   input  logic                          err_clr,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_empty,
   output logic                          rx_full,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overrun
);

   localparam int unsigned CW = $clog2(OVERSAMPLE);
   localparam int unsigned H  = OVERSAMPLE / 2;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned BW = $clog2(DATA_BITS);

   localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] CNT_HM1  = CW'(H - 1);
   localparam logic [CW-1:0] CNT_H    = CW'(H);
   localparam logic [CW-1:0] CNT_HP1  = CW'(H + 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_bad_cfg
      $error("uart_rx_param: illegal parameter set");
   end

`ifdef UART_RX_PARITY_EN
   localparam logic PAR_ODD = (PARITY_ODD != 0);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
`endif

   state_t state, state_nxt;

   logic                 sync1, rx_s;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 v0, v1, vote;
   logic                 wr_req, fe_set, pe_set;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad;
`endif

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW:0]          wr_ptr, rd_ptr;
   logic                 fifo_empty, fifo_full, do_rd, do_wr;

   // Synchroniser presets to idle level so reset release never looks like a start bit
   always_ff @(posedge clk_rf or negedge rst_n_rf) begin
      if (!rst_n_rf) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= rx_in;
         rx_s  <= sync1;
      end
   end

   assign vote = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);

   always_ff @(posedge clk_rf or negedge rst_n_rf) begin
      if (!rst_n_rf) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wr_req    = 1'b0;
      fe_set    = 1'b0;
      pe_set    = 1'b0;
      case (state)
         IDLE:    if (!rx_s) state_nxt = START;
         START: begin
            if (cnt == CNT_HP1 && vote) state_nxt = IDLE;
            else if (cnt == CNT_LAST)   state_nxt = DATA;
         end
         DATA: begin
            if (cnt == CNT_LAST && bit_idx == BIT_LAST)
`ifdef UART_RX_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         PARITY:  if (cnt == CNT_LAST) state_nxt = STOP;
`endif
         STOP: begin
            if (cnt == CNT_HP1) begin
               if (!vote) begin
                  fe_set    = 1'b1;
                  state_nxt = WAIT_HI;
`ifdef UART_RX_PARITY_EN
               end else if (par_bad) begin
                  pe_set    = 1'b1;
                  state_nxt = IDLE;
`endif
               end else begin
                  wr_req    = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         WAIT_HI: if (rx_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_rf or negedge rst_n_rf) begin
      if (!rst_n_rf) begin
         cnt     <= '0;
         v0      <= 1'b1;
         v1      <= 1'b1;
         bit_idx <= '0;
         shreg   <= '0;
`ifdef UART_RX_PARITY_EN
         par_bad <= 1'b0;
`endif
      end else begin
         if (state_nxt != state || cnt == CNT_LAST) cnt <= '0;
         else                                       cnt <= cnt + 1'b1;
         if (cnt == CNT_HM1) v0 <= rx_s;
         if (cnt == CNT_H)   v1 <= rx_s;
         if (state == START)                        bit_idx <= '0;
         else if (state == DATA && cnt == CNT_LAST) bit_idx <= bit_idx + 1'b1;
         // LSB arrives first, so shifting in at the MSB leaves the word aligned after the last bit
         if (state == DATA && cnt == CNT_HP1) shreg <= {vote, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
         if (state == PARITY && cnt == CNT_HP1) par_bad <= vote ^ (^shreg) ^ PAR_ODD;
`endif
      end
   end

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_rd      = rd_en && !fifo_empty;
   // A pop in the same cycle frees the slot, so a write into a full FIFO still lands
   assign do_wr      = wr_req && (!fifo_full || do_rd);

   always_ff @(posedge clk_rf) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= shreg;
   end

   always_ff @(posedge clk_rf or negedge rst_n_rf) begin
      if (!rst_n_rf) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign rx_data  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign rx_empty = fifo_empty;
   assign rx_full  = fifo_full;
   assign rx_count = wr_ptr - rd_ptr;

   always_ff @(posedge clk_rf or negedge rst_n_rf) begin
      if (!rst_n_rf) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= fe_set | (frame_err & ~err_clr);
         overrun   <= (wr_req & fifo_full & ~do_rd) | (overrun & ~err_clr);
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk_rf or negedge rst_n_rf) begin
      if (!rst_n_rf) parity_err <= 1'b0;
      else           parity_err <= pe_set | (parity_err & ~err_clr);
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule
